md5_pad_feeder: RTL and testbench

Front-end producer for the MD5 core: accepts a message as a byte stream, packs bytes little-endian into 32-bit words, and emits fully padded 512-bit blocks as a stream of 16 words with an index, plus a block-last and a message-last marker. It is the transmit side of the core's word input. The core consumes one word per handshake and starts compression on `wlast_blk_o`. Padding follows RFC 1321:

- 0x80 marker byte.
- Zero fill up to byte 56 mod 64.
- 64-bit bit length, low word first.

---
 rtl/md5_pad_feeder_if.sv | 25 ++
 rtl/md5_pad_feeder.sv | 148 ++++++++++++++
 tb/tb_md5_pad_feeder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_pad_feeder_if.sv
// Byte-in / word-out handshake bundle for md5_pad_feeder.
// master = the feeder (sinks bytes, sources words); slave = the byte source plus MD5 core.
`timescale 1ns/1ps
interface md5_pad_feeder_if;
  logic [7:0]  in_byte_i;
  logic        in_vld_i;
  logic        in_last_i;
  logic        in_rdy_o;
  logic [31:0] word_o;
  logic [3:0]  widx_o;
  logic        wvalid_o;
  logic        wready_i;
  logic        wlast_blk_o;
  logic        wlast_msg_o;

  modport master (
    input  in_byte_i, in_vld_i, in_last_i, wready_i,
    output in_rdy_o, word_o, widx_o, wvalid_o, wlast_blk_o, wlast_msg_o
  );

  modport slave (
    output in_byte_i, in_vld_i, in_last_i, wready_i,
    input  in_rdy_o, word_o, widx_o, wvalid_o, wlast_blk_o, wlast_msg_o
  );
endinterface

// File: rtl/md5_pad_feeder.sv
// RFC 1321 padding front end: packs bytes into LE words and emits padded 512-bit blocks.
// Optional block counter output blk_cnt_o is enabled by defining MD5_PAD_BLKCNT_EN.
`timescale 1ns/1ps
module md5_pad_feeder #(
  parameter int LEN_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  md5_pad_feeder_if.master      bus
`ifdef MD5_PAD_BLKCNT_EN
  ,
  output logic [15:0]           blk_cnt_o
`endif
);

  typedef enum logic [2:0] {DATA, PAD80, ZERO, LEN_LO, LEN_HI} state_t;

  state_t           state;
  logic [LEN_W-1:0] byte_cnt;
  logic [23:0]      acc;        // lanes 0..2 of the word being assembled
  logic [3:0]       nidx;       // index the next loaded word will carry
  logic [1:0]       lane;
  logic             out_free;
  logic             in_fire;
  logic             pad_to_len;
  logic [63:0]      bitlen;
  logic [31:0]      data_word;
  logic             load_en;
  logic [31:0]      load_word;
  logic             load_msg;

  assign lane       = byte_cnt[1:0];
  assign out_free   = !bus.wvalid_o || bus.wready_i;
  assign bus.in_rdy_o = !rst_i && (state == DATA) && out_free;
  assign in_fire    = bus.in_vld_i && bus.in_rdy_o;
  assign pad_to_len = (nidx == 4'd13);
  assign bitlen     = 64'({byte_cnt, 3'b000});

  // Final partial word carries the 0x80 marker in the lane after the last byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    data_word = {bus.in_byte_i, acc};
    if (bus.in_last_i) begin
      unique case (lane)
        2'd0:    data_word = {16'h0000, 8'h80, bus.in_byte_i};
        2'd1:    data_word = {8'h00, 8'h80, bus.in_byte_i, acc[7:0]};
        2'd2:    data_word = {8'h80, bus.in_byte_i, acc[15:0]};
        default: data_word = {bus.in_byte_i, acc};
      endcase
    end
  end

  always_comb begin
    load_en   = 1'b0;
    load_word = 32'h0000_0000;
    load_msg  = 1'b0;
    unique case (state)
      DATA: begin
        load_en   = in_fire && ((lane == 2'd3) || bus.in_last_i);
        load_word = data_word;
      end
      PAD80: begin
        load_en   = out_free;
        load_word = 32'h0000_0080;
      end
      ZERO:    load_en = out_free;
      LEN_LO: begin
        load_en   = out_free;
        load_word = bitlen[31:0];
      end
      LEN_HI: begin
        load_en   = out_free;
        load_word = bitlen[63:32];
        load_msg  = 1'b1;
      end
      default: load_en = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= DATA;
      byte_cnt        <= '0;
      acc             <= '0;
      nidx            <= '0;
      bus.word_o      <= '0;
      bus.widx_o      <= '0;
      bus.wvalid_o    <= 1'b0;
      bus.wlast_blk_o <= 1'b0;
      bus.wlast_msg_o <= 1'b0;
    end else begin
      if (load_en) begin
        bus.word_o      <= load_word;
        bus.widx_o      <= nidx;
        bus.wvalid_o    <= 1'b1;
        bus.wlast_blk_o <= (nidx == 4'd15);
        bus.wlast_msg_o <= load_msg;
        nidx            <= nidx + 4'd1;
      end else if (out_free) begin
        bus.wvalid_o    <= 1'b0;
        bus.wlast_blk_o <= 1'b0;
        bus.wlast_msg_o <= 1'b0;
      end

      unique case (state)
        DATA: begin
          if (in_fire) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (bus.in_last_i) begin
              state <= (lane == 2'd3) ? PAD80 : (pad_to_len ? LEN_LO : ZERO);
            end else begin
              unique case (lane)
                2'd0:    acc[7:0]   <= bus.in_byte_i;
                2'd1:    acc[15:8]  <= bus.in_byte_i;
                2'd2:    acc[23:16] <= bus.in_byte_i;
                default: acc        <= acc;
              endcase
            end
          end
        end
        PAD80:  if (load_en) state <= pad_to_len ? LEN_LO : ZERO;
        ZERO:   if (load_en && pad_to_len) state <= LEN_LO;
        LEN_LO: if (load_en) state <= LEN_HI;
        LEN_HI: begin
          if (load_en) begin
            state    <= DATA;
            byte_cnt <= '0;
            nidx     <= '0;
          end
        end
        default: state <= DATA;
      endcase
    end
  end

`ifdef MD5_PAD_BLKCNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blk_cnt_o <= '0;
    end else if (bus.wvalid_o && bus.wready_i && bus.wlast_blk_o) begin
      blk_cnt_o <= blk_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md5_pad_feeder.sv
// Scoreboard bench for md5_pad_feeder: an RFC 1321 padding model queues the expected words.
`timescale 1ns/1ps
module tb_md5_pad_feeder;

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  idx;
    logic        lblk;
    logic        lmsg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md5_pad_feeder_if bus();
`ifdef MD5_PAD_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  md5_pad_feeder #(.LEN_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
`ifdef MD5_PAD_BLKCNT_EN
    ,
    .blk_cnt_o (blk_cnt)
`endif
  );

  int          n_checks   = 0;
  int          n_fail     = 0;
  int          exp_blocks = 0;
  exp_t        exp_q[$];
  logic [7:0]  msg[$];
  logic [7:0]  msg100[$];
  bit          sb_en      = 1'b1;
  bit          stall_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit LE bit length.
  function automatic void model_push();
    logic [7:0]  pad[$];
    logic [63:0] bits;
    int          nw;
    pad = msg;
    pad.push_back(8'h80);
    while ((pad.size() % 64) != 56) pad.push_back(8'h00);
    bits = 64'(msg.size()) << 3;
    for (int i = 0; i < 8; i++) pad.push_back(bits[8*i +: 8]);
    nw = pad.size() / 4;
    for (int w = 0; w < nw; w++) begin
      exp_t e;
      e.word = {pad[4*w+3], pad[4*w+2], pad[4*w+1], pad[4*w]};
      e.idx  = 4'(w % 16);
      e.lblk = ((w % 16) == 15);
      e.lmsg = (w == nw - 1);
      exp_q.push_back(e);
    end
    exp_blocks += pad.size() / 64;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.wready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop on every accepted word, hold checks during stalls.
  exp_t        mon_e;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_word;
  logic [3:0]  prev_idx;
  logic        prev_lblk;
  logic        prev_lmsg;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_word", 64'(bus.word_o), 64'(prev_word));
        check("stall_idx", 64'(bus.widx_o), 64'(prev_idx));
        check("stall_lblk", 64'(bus.wlast_blk_o), 64'(prev_lblk));
        check("stall_lmsg", 64'(bus.wlast_msg_o), 64'(prev_lmsg));
      end
      if (bus.wvalid_o && !bus.wready_i) check("stall_in_rdy", 64'(bus.in_rdy_o), 64'd0);
      if (bus.wvalid_o && bus.wready_i && sb_en) begin
        check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("word", 64'(bus.word_o), 64'(mon_e.word));
          check("widx", 64'(bus.widx_o), 64'(mon_e.idx));
          check("wlast_blk", 64'(bus.wlast_blk_o), 64'(mon_e.lblk));
          check("wlast_msg", 64'(bus.wlast_msg_o), 64'(mon_e.lmsg));
        end
      end
      prev_stall = bus.wvalid_o && !bus.wready_i;
      prev_word  = bus.word_o;
      prev_idx   = bus.widx_o;
      prev_lblk  = bus.wlast_blk_o;
      prev_lmsg  = bus.wlast_msg_o;
    end
  end

  task automatic wait_accept();
    int t    = 0;
    bit done = 1'b0;
    while (!done && t < 1000) begin
      @(negedge clk);
      if (bus.in_rdy_o) done = 1'b1;
      else t++;
    end
    check("byte_accept", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input bit expect_out, input bit with_last);
    if (expect_out) model_push();
    for (int i = 0; i < msg.size(); i++) begin
      bus.in_byte_i = msg[i];
      bus.in_vld_i  = 1'b1;
      bus.in_last_i = with_last && (i == msg.size() - 1);
      wait_accept();
    end
    bus.in_vld_i  = 1'b0;
    bus.in_last_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
`ifdef MD5_PAD_BLKCNT_EN
    check("blk_cnt", 64'(blk_cnt), 64'(exp_blocks));
`endif
  endtask

  task automatic fill_msg(input int n, input logic [7:0] b);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wvalid"}, 64'(bus.wvalid_o), 64'd0);
    check({tag, "_word"}, 64'(bus.word_o), 64'd0);
    check({tag, "_widx"}, 64'(bus.widx_o), 64'd0);
    check({tag, "_lblk"}, 64'(bus.wlast_blk_o), 64'd0);
    check({tag, "_lmsg"}, 64'(bus.wlast_msg_o), 64'd0);
    check({tag, "_in_rdy"}, 64'(bus.in_rdy_o), 64'd0);
`ifdef MD5_PAD_BLKCNT_EN
    check({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
`endif
  endtask

  initial begin
    bus.in_byte_i = 8'h00;
    bus.in_vld_i  = 1'b0;
    bus.in_last_i = 1'b0;
    bus.wready_i  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    msg = {8'h61, 8'h62, 8'h63};
    send_msg(1'b1, 1'b1);
    drain();

    msg = {8'h61, 8'h62, 8'h63, 8'h64};
    send_msg(1'b1, 1'b1);
    drain();

    fill_msg(55, 8'h41);
    send_msg(1'b1, 1'b1);
    drain();

    fill_msg(56, 8'h41);
    send_msg(1'b1, 1'b1);
    drain();

    fill_msg(1, 8'hA5);
    send_msg(1'b1, 1'b1);
    drain();

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(0, 255)));
    send_msg(1'b1, 1'b1);
    drain();

    msg100.delete();
    for (int i = 0; i < 100; i++) msg100.push_back(8'($urandom_range(0, 255)));
    msg = msg100;
    send_msg(1'b1, 1'b1);
    drain();

    stall_mode = 1'b1;
    msg = msg100;
    send_msg(1'b1, 1'b1);
    drain();
    stall_mode = 1'b0;
    @(posedge clk);
    #1;

    // Abort a message mid-word; the partial state must vanish with reset.
    sb_en = 1'b0;
    fill_msg(6, 8'h5A);
    send_msg(1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    sb_en      = 1'b1;
    exp_blocks = 0;
    msg = {8'h61, 8'h62, 8'h63};
    send_msg(1'b1, 1'b1);
    drain();
    repeat (4) @(negedge clk);
    check("idle_after_abc", 64'(bus.wvalid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
